booth_seq_multiplier: RTL and testbench



---
 rtl/booth_seq_multiplier.sv | 113 +++++++++++
 tb/tb_booth_seq_multiplier.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: WIDTH x WIDTH -> {ZHI, ZLO}, WIDTH/2+1 steps plus a DONE cycle.
// Optional unsigned mode is compiled in with MUL_UNSIGNED_EN; otherwise every operation is signed.
module booth_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             mode_unsigned,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] ZHI,
    output logic [WIDTH-1:0] ZLO,
    output logic             busy,
    output logic             done
);

    localparam int AW = WIDTH + 4;
    localparam int QW = WIDTH + 2;
    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   acc, m_ext, addend, acc_sum, acc_shift;
    logic [QW-1:0]   q, q_shift, a_ext, b_ext;
    logic            qm1;
    logic [CW-1:0]   cnt;
    logic            last_step;
    logic            ext_zero;
    logic [2*WIDTH-1:0] product;

`ifdef MUL_UNSIGNED_EN
    assign ext_zero = mode_unsigned;
`else
    logic unused_mode;
    assign unused_mode = mode_unsigned;
    assign ext_zero    = 1'b0;
`endif

    assign a_ext = {{2{mcand[WIDTH-1] & ~ext_zero}}, mcand};
    assign b_ext = {{2{mplier[WIDTH-1] & ~ext_zero}}, mplier};

    always_comb begin
        addend = '0;
        case ({q[1], q[0], qm1})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
    end

    assign acc_sum   = acc + addend;
    assign acc_shift = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
    assign q_shift   = {acc_sum[1:0], q[QW-1:2]};
    // Low 2*WIDTH bits of the post-shift {acc, q} pair.
    assign product   = {acc_sum[WIDTH-1:2], q_shift};
    assign last_step = (cnt == CW'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            acc   <= '0;
            m_ext <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            ZHI   <= '0;
            ZLO   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        m_ext <= {{2{a_ext[QW-1]}}, a_ext};
                        q     <= b_ext;
                        qm1   <= 1'b0;
                        cnt   <= CW'(N);
                    end
                end
                RUN: begin
                    acc <= acc_shift;
                    q   <= q_shift;
                    qm1 <= q[1];
                    cnt <= cnt - CW'(1);
                    if (last_step) {ZHI, ZLO} <= product;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier: directed corner cases, busy/ignored-start/reset behaviour,
// then random operands compared against a plain-arithmetic product model.
module tb_booth_seq_multiplier;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic        mode_unsigned = 1'b0;
    logic [31:0] mcand = '0;
    logic [31:0] mplier = '0;
    logic [31:0] ZHI, ZLO;
    logic        busy, done;

    int errors = 0;
    int checks = 0;
    logic [63:0] held = '0;

    booth_seq_multiplier #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr), .start(start), .mode_unsigned(mode_unsigned),
        .mcand(mcand), .mplier(mplier), .ZHI(ZHI), .ZLO(ZLO), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic mu);
        longint sa, sb;
`ifdef MUL_UNSIGNED_EN
        if (mu) return {32'b0, a} * {32'b0, b};
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // inj_at: edge index at which a spurious start with new operands is presented (0 = none).
    // rst_at: edge index after which clr is pulsed mid-cycle (0 = none).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic mu,
                          input int inj_at, input int rst_at,
                          output int lat, output int bcnt, output int ndone);
        @(negedge clk);
        start = 1'b1; mcand = a; mplier = b; mode_unsigned = mu;
        @(posedge clk); #1;
        start = 1'b0; mcand = $urandom; mplier = $urandom; mode_unsigned = 1'($urandom);
        lat = -1; ndone = 0;
        bcnt = busy ? 1 : 0;
        check("busy_after_accept", {63'b0, busy}, 64'd1);
        for (int i = 1; i <= 60; i++) begin
            if (inj_at != 0 && i == inj_at) begin
                start = 1'b1; mcand = $urandom; mplier = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (rst_at != 0 && i == rst_at) begin
                #2 clr = 1'b0;
                #1;
                check("rst_zhi_zlo", {ZHI, ZLO}, 64'd0);
                check("rst_busy_done", {62'b0, busy, done}, 64'd0);
                #1 clr = 1'b1;
                held = '0;
                lat = 0;
                return;
            end
            if (busy) bcnt++;
            if (done) begin
                ndone++;
                if (lat < 0) lat = i;
            end
            if (i == 5) check("hold_mid_op", {ZHI, ZLO}, held);
            if (!busy && lat >= 0) break;
        end
        if (lat < 0) check("timeout_no_done", 64'd0, 64'd1);
    endtask

    task automatic full_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic mu, input logic [63:0] exp);
        int lat, bcnt, nd;
        run_op(a, b, mu, 0, 0, lat, bcnt, nd);
        check({tag, "_prod"}, {ZHI, ZLO}, exp);
        check({tag, "_lat"}, 64'(lat), 64'd17);
        held = exp;
    endtask

    initial begin
        int lat, bcnt, nd;
        logic [31:0] ra, rb;
        logic rm;

        #12;
        check("reset_out", {ZHI, ZLO}, 64'd0);
        check("reset_busy_done", {62'b0, busy, done}, 64'd0);
        @(negedge clk); clr = 1'b1;

        full_op("f_x_4", 32'h0000000F, 32'h00000004, 1'b0, 64'h3C);
        full_op("m1_x_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h1);
        full_op("min_x_min", 32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000);
`ifdef MUL_UNSIGNED_EN
        full_op("u_ff_x_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE00000001);
`else
        full_op("u_ff_x_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1);
`endif

        // 3 x -2 also checks busy width and that busy/done drop on the following edge.
        run_op(32'h3, 32'hFFFFFFFE, 1'b0, 0, 0, lat, bcnt, nd);
        check("3_x_m2_prod", {ZHI, ZLO}, 64'hFFFFFFFFFFFFFFFA);
        check("3_x_m2_busy_cycles", 64'(bcnt), 64'd18);
        check("3_x_m2_idle_after", {62'b0, busy, done}, 64'd0);
        held = 64'hFFFFFFFFFFFFFFFA;

        full_op("12_x_4", 32'h12, 32'h4, 1'b0, 64'h48);
        run_op(32'h5, 32'h6, 1'b0, 5, 0, lat, bcnt, nd);
        check("ignored_start_prod", {ZHI, ZLO}, 64'h1E);
        check("ignored_start_ndone", 64'(nd), 64'd1);
        check("ignored_start_lat", 64'(lat), 64'd17);
        held = 64'h1E;

        run_op(32'h7, 32'h3, 1'b0, 0, 8, lat, bcnt, nd);
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        check("no_done_after_reset", 64'(nd), 64'd0);
        full_op("7_x_3_after_rst", 32'h7, 32'h3, 1'b0, 64'h15);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: begin ra = 32'h80000000; rb = $urandom; end
                1: begin ra = $urandom; rb = 32'h7FFFFFFF; end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            rm = 1'($urandom);
            full_op("rand", ra, rb, rm, ref_mul(ra, rb, rm));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
